// File: rtl/sha_pad_gen.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks and appends 0x80, zero fill and the 64-bit length.
// Optional SHA_PAD_PARTIAL_EN honours in_bytes for byte-granular messages; without it every last word is a full word.
module sha_pad_gen (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  input  logic [2:0]        in_bytes,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [15:0][31:0] blk_W,
  output logic              blk_first,
  output logic              blk_last,
  output logic [1:0]        state_dbg
);

  // Handshakes: a word moves when in_valid && in_ready at a rising edge; a block moves when
  // blk_valid && blk_ready at a rising edge. blk_W and flags hold while blk_valid && !blk_ready.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    EMIT   = 2'd1,
    LENBLK = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wi;
  logic [60:0] bc;
  logic        first_pend;
  logic        len_pend;
  logic        mark_pend;

  logic [2:0]        k;
  logic [2:0]        add_bytes;
  logic [31:0]       word_m;
  logic [60:0]       bc_nxt;
  logic [63:0]       len_nxt;
  logic [4:0]        wi5;
  logic [4:0]        mpos;
  logic [15:0][31:0] last_blk;
  logic [15:0][31:0] len_blk;

  assign in_ready  = reset && (state == FILL);
  assign state_dbg = state;

`ifdef SHA_PAD_PARTIAL_EN
  always_comb begin
    k      = ((in_bytes >= 3'd1) && (in_bytes <= 3'd4)) ? in_bytes : 3'd4;
    word_m = in_data;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) == k) begin
        word_m[31-8*b -: 8] = 8'h80;
      end else if (3'(b) > k) begin
        word_m[31-8*b -: 8] = 8'h00;
      end
    end
  end
`else
  logic unused_in_bytes;
  assign unused_in_bytes = ^in_bytes;
  assign k      = 3'd4;
  assign word_m = in_data;
`endif

  assign add_bytes = in_last ? k : 3'd4;
  assign bc_nxt    = bc + 61'(add_bytes);
  assign len_nxt   = {bc_nxt, 3'b000};
  assign wi5       = {1'b0, wi};
  // A full last word pushes the marker into the following word (16 means the next block).
  assign mpos      = (k == 3'd4) ? (wi5 + 5'd1) : wi5;

  always_comb begin
    last_blk = '0;
    for (int j = 0; j < 16; j++) begin
      if (5'(j) < wi5) begin
        last_blk[15-j] = blk_W[15-j];
      end else if (5'(j) == wi5) begin
        last_blk[15-j] = word_m;
      end else if (5'(j) == mpos) begin
        last_blk[15-j] = 32'h8000_0000;
      end else begin
        last_blk[15-j] = 32'h0;
      end
    end
    if (mpos <= 5'd13) begin
      last_blk[1] = len_nxt[63:32];
      last_blk[0] = len_nxt[31:0];
    end
  end

  always_comb begin
    len_blk = '0;
    if (mark_pend) begin
      len_blk[15] = 32'h8000_0000;
    end
    len_blk[1] = bc[60:29];
    len_blk[0] = {bc[28:0], 3'b000};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      wi         <= 4'd0;
      bc         <= '0;
      first_pend <= 1'b1;
      len_pend   <= 1'b0;
      mark_pend  <= 1'b0;
      blk_valid  <= 1'b0;
      blk_first  <= 1'b0;
      blk_last   <= 1'b0;
      blk_W      <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid && in_ready) begin
            bc <= bc_nxt;
            if (in_last) begin
              blk_W      <= last_blk;
              blk_last   <= (mpos <= 5'd13);
              len_pend   <= (mpos >= 5'd14);
              mark_pend  <= (mpos == 5'd16);
              blk_valid  <= 1'b1;
              blk_first  <= first_pend;
              first_pend <= 1'b0;
              state      <= EMIT;
            end else begin
              blk_W[4'd15 - wi] <= in_data;
              wi                <= wi + 4'd1;
              if (wi == 4'd15) begin
                blk_last   <= 1'b0;
                len_pend   <= 1'b0;
                mark_pend  <= 1'b0;
                blk_valid  <= 1'b1;
                blk_first  <= first_pend;
                first_pend <= 1'b0;
                state      <= EMIT;
              end
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            wi <= 4'd0;
            if (len_pend) begin
              // Length block goes out directly behind this one without a bubble.
              blk_W     <= len_blk;
              blk_first <= 1'b0;
              blk_last  <= 1'b1;
              len_pend  <= 1'b0;
              mark_pend <= 1'b0;
              state     <= LENBLK;
            end else begin
              if (blk_last) begin
                bc         <= '0;
                first_pend <= 1'b1;
              end
              blk_valid <= 1'b0;
              blk_first <= 1'b0;
              blk_last  <= 1'b0;
              state     <= FILL;
            end
          end
        end
        LENBLK: begin
          if (blk_ready) begin
            bc         <= '0;
            first_pend <= 1'b1;
            wi         <= 4'd0;
            blk_valid  <= 1'b0;
            blk_last   <= 1'b0;
            state      <= FILL;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_pad_gen.sv
// Self-checking bench for sha_pad_gen: directed padding cases plus random messages against a byte-level padding model.
// Honours SHA_PAD_PARTIAL_EN the same way the design does.
module tb_sha_pad_gen;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic [2:0]        in_bytes = 3'd4;
  logic              blk_valid;
  logic              blk_ready = 1'b0;
  logic [15:0][31:0] blk_W;
  logic              blk_first;
  logic              blk_last;
  logic [1:0]        state_dbg;

  int          n_checks = 0;
  int          n_err = 0;
  bit          rdy_rand = 1'b0;
  logic [511:0] exp_q[$];
  logic [1:0]   expf_q[$];
  logic [31:0]  msg_w[$];
  logic [2:0]   msg_kraw;
  logic [511:0] mon_e;
  logic [1:0]   mon_f;

  sha_pad_gen dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_W     (blk_W),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rdy_rand) blk_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted block is compared with the model's next block
  always @(negedge clk) begin
    if (reset && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_blk", 512'(exp_q.size()), 512'd1);
      end else begin
        mon_e = exp_q.pop_front();
        mon_f = expf_q.pop_front();
        check("blk_data", 512'(blk_W), mon_e);
        check("blk_flags", 512'({blk_first, blk_last}), 512'(mon_f));
      end
    end
  end

  // reference: pad the message as a byte string, then cut it into 64-byte blocks
  task automatic model_push();
    logic [7:0]   pq[$];
    int           n;
    int           ke;
    int           nblk;
    logic [63:0]  len;
    logic [511:0] blk;
    ke = 4;
`ifdef SHA_PAD_PARTIAL_EN
    if (msg_kraw >= 3'd1 && msg_kraw <= 3'd4) ke = int'(msg_kraw);
`endif
    n = msg_w.size();
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++)
        if (i < n - 1 || b < ke) pq.push_back(msg_w[i][31-8*b -: 8]);
    len = 64'(pq.size()) * 64'd8;
    pq.push_back(8'h80);
    while (pq.size() % 64 != 56) pq.push_back(8'h00);
    for (int b = 7; b >= 0; b--) pq.push_back(len[8*b +: 8]);
    nblk = pq.size() / 64;
    for (int q = 0; q < nblk; q++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk = {blk[503:0], pq[64*q+i]};
      exp_q.push_back(blk);
      expf_q.push_back({q == 0, q == nblk - 1});
    end
  endtask

  task automatic gen_msg(input int nw, input logic [2:0] kraw);
    msg_w.delete();
    for (int i = 0; i < nw; i++) msg_w.push_back($urandom());
    msg_kraw = kraw;
  endtask

  // driver: returns 1 time unit after the accepting edge
  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] kb);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_bytes = kb;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n >= 300) begin
        check("in_timeout", 512'(n), 512'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drive_range(input int from, input int to);
    for (int i = from; i < to; i++) begin
      if (rdy_rand && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send_word(msg_w[i], i == msg_w.size() - 1, msg_kraw);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 512'(exp_q.size()), 512'd0);
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [511:0] snap;
  logic [1:0]   snapf;

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 512'(in_ready), 512'd0);
    check("rst_blk_valid", 512'(blk_valid), 512'd0);
    check("rst_blk_W", 512'(blk_W), 512'd0);
    check("rst_flags", 512'({blk_first, blk_last}), 512'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", 512'(in_ready), 512'd1);
    @(posedge clk);
    #1;

    // "abc"
    blk_ready = 1'b1;
    msg_w.delete();
    msg_w.push_back(32'h6162_6300);
    msg_kraw = 3'd3;
    model_push();
    send_word(msg_w[0], 1'b1, msg_kraw);
    @(negedge clk);
    check("abc_lat", 512'(blk_valid), 512'd1);
    check("abc_flags", 512'({blk_first, blk_last}), 512'd3);
`ifdef SHA_PAD_PARTIAL_EN
    check("abc_w0", 512'(blk_W[15]), 512'h6162_6380);
    check("abc_w15", 512'(blk_W[0]), 512'h18);
`else
    check("abc_w0", 512'(blk_W[15]), 512'h6162_6300);
    check("abc_w15", 512'(blk_W[0]), 512'h20);
`endif
    drain();

    // 55 bytes
    gen_msg(14, 3'd3);
    model_push();
    drive_range(0, 14);
    @(negedge clk);
`ifdef SHA_PAD_PARTIAL_EN
    check("b55_w13", 512'(blk_W[2][7:0]), 512'h80);
    check("b55_w15", 512'(blk_W[0]), 512'h1B8);
`else
    check("b55_w14", 512'(blk_W[1]), 512'h8000_0000);
    check("b55_last", 512'(blk_last), 512'd0);
`endif
    drain();

    // 56 bytes: marker fills W14, length goes to a second block
    gen_msg(14, 3'd4);
    model_push();
    drive_range(0, 14);
    @(negedge clk);
    check("b56_w14", 512'(blk_W[1]), 512'h8000_0000);
    check("b56_last", 512'(blk_last), 512'd0);
    @(negedge clk);
    check("b56_len_lat", 512'(blk_valid), 512'd1);
    check("b56_len_flags", 512'({blk_first, blk_last}), 512'd1);
    check("b56_len_w15", 512'(blk_W[0]), 512'h1C0);
    drain();

    // 64 bytes: marker deferred to W0 of the length block
    gen_msg(16, 3'd4);
    model_push();
    drive_range(0, 16);
    @(negedge clk);
    check("b64_last", 512'(blk_last), 512'd0);
    @(negedge clk);
    check("b64_w0", 512'(blk_W[15]), 512'h8000_0000);
    check("b64_w15", 512'(blk_W[0]), 512'h200);
    drain();

    // backpressure during EMIT with a word offered
    blk_ready = 1'b0;
    gen_msg(20, 3'd2);
    model_push();
    drive_range(0, 16);
    in_valid = 1'b1;
    in_data  = msg_w[16];
    in_last  = 1'b0;
    @(negedge clk);
    snap  = 512'(blk_W);
    snapf = {blk_first, blk_last};
    check("bp_valid", 512'(blk_valid), 512'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 512'(in_ready), 512'd0);
      check("bp_hold_W", 512'(blk_W), snap);
      check("bp_hold_flags", 512'({blk_first, blk_last}), 512'(snapf));
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    blk_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release", 512'({blk_valid, in_ready}), 512'b01);
    @(posedge clk);
    #1;
    drive_range(16, 20);
    drain();

    // reset mid-message, then "abc" again
    gen_msg(10, 3'd4);
    drive_range(0, 7);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 512'(blk_valid), 512'd0);
    check("mid_rst_ready", 512'(in_ready), 512'd0);
    check("mid_rst_W", 512'(blk_W), 512'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    msg_w.delete();
    msg_w.push_back(32'h6162_6300);
    msg_kraw = 3'd3;
    model_push();
    send_word(msg_w[0], 1'b1, msg_kraw);
    drain();

    // random messages, random gaps and random output backpressure
    rdy_rand = 1'b1;
    for (int m = 0; m < 25; m++) begin
      gen_msg($urandom_range(1, 40), 3'($urandom_range(0, 7)));
      model_push();
      drive_range(0, msg_w.size());
    end
    rdy_rand = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sha_pad_gen.md
# sha_pad_gen

Message formatter that feeds the SHA-256 compression stage. It accepts a message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit bit-length. It emits complete 512-bit blocks in the compression core's `W_in` word order, flagged first/last so the downstream hash core knows when to load the IV and when the digest is final. It sits between the host/DMA word interface and the hash core.

## Interface
- No parameters. Fixed: 32-bit words, 16 words per block, 64-bit length field.
- `clk`  input  1  — sole clock; all state updates on the rising edge.
- `reset`  input  1  — asynchronous, active-low reset.
- `in_valid`  input  1  — `in_data` word is valid.
- `in_ready`  output  1  — block can accept a word this cycle.
- `in_data`  input  32  — message word; the first byte is in [31:24].
- `in_last`  input  1  — this word is the final word of the message.
- `in_bytes`  input  3  — valid bytes in the last word, 1..4. Sampled only with `in_last`.
- `blk_valid`  output  1  — `blk_W` holds a complete block.
- `blk_ready`  input  1  — downstream accepts the block.
- `blk_W`  output  16x32  — packed [15:0][31:0]. `blk_W[15]` = W0 (first word), `blk_W[0]` = W15.
- `blk_first`  output  1  — block is the first block of a message.
- `blk_last`  output  1  — block is the final, padded block of a message.

## Operation
- **States:** FILL, EMIT, LENBLK.
- **FILL**
  - `in_ready`=1.
  - Each handshake writes word index `wi` (0..15) and adds bytes to a 61-bit byte counter `bc`.
  - Bit length is L = {bc, 3'b000}. It wraps modulo 2^64; no error is raised.
- **Non-last word at `wi`=15:** go to EMIT with `blk_last`=0.
- **Last word with k = `in_bytes`:**
  - Bytes beyond k are forced to zero regardless of `in_data`.
  - If k<4, byte k of that word becomes 0x80.
  - In the same cycle, every word above the marker is zeroed.
- **Marker placement and block count:**
  - If the marker lands in word ≤13: W14/W15 = L[63:32]/L[31:0]. Go to EMIT with `blk_last`=1.
  - If the marker lands in word 14 or 15: emit this block with `blk_last`=0. Then LENBLK.
  - If k=4 at `wi`=15: the marker moves to the next block. Emit, then LENBLK with W0=0x80000000.
- **LENBLK:**
  - Block is all zero except the deferred marker, if any, and L in W14/W15.
  - `blk_first`=0, `blk_last`=1.
- **EMIT**
  - `blk_valid`=1. `blk_W`, `blk_first` and `blk_last` are held stable until `blk_ready`.
  - After the handshake: go to LENBLK if a length block is pending. Otherwise go to FILL with `wi`=0.
  - After a `blk_last` handshake: also clear `bc` and set the first flag for the next message.
- **Flag rules:**
  - `blk_first` is set for the first block emitted after reset or after a `blk_last` handshake.
  - A block may carry both `blk_first` and `blk_last`.
- **Unsupported input:** zero-length messages. `in_bytes` values 0, 5, 6, 7 are treated as 4.

## Timing
- **Reset values:**
  - `in_ready`=0 while `reset` is low. `blk_valid`, `blk_first`, `blk_last`=0. `blk_W`=0.
  - State returns to FILL with `wi`=0, `bc`=0 and the first flag set.
  - `in_ready`=1 in the first cycle after reset deasserts.
- **Latency:** `blk_valid` rises the cycle after the handshake of the 16th word or the last word.
- **Length block:** rises the cycle after the preceding block's handshake. No bubble beyond that.
- **Input backpressure:** `in_ready`=0 in EMIT and LENBLK; no input buffering beyond the block register.
- **Throughput:** full-rate input gives 17 cycles per block when `blk_ready` is held high.
- **Output handshake:** completes in any cycle where `blk_valid` and `blk_ready` are both high. `blk_ready` may be high before `blk_valid`.
- **Reset mid-message:** the partial block, byte count and pending length block are discarded. Nothing is emitted.

## Configuration
- **`SHA_PAD_PARTIAL_EN` defined:** `in_bytes` is honoured as described, giving byte-granular messages.
- **Not defined:**
  - `in_bytes` is ignored and every last word is treated as k=4, so messages are word-granular.
  - The byte masking logic is removed, and `bc` advances by 4 per word.

## Test plan
- **"abc":** `in_data`=0x61626300, `in_last`=1, `in_bytes`=3.
  - Expect one block: W0=0x61626380, W1..W14=0, W15=0x00000018, `blk_first`=`blk_last`=1.
- **55 bytes** (13 full words + last word k=3).
  - Expect one block: W13 low byte=0x80, W14=0, W15=0x000001B8.
- **56 bytes** (14 words, last k=4).
  - Block 1: W14=0x80000000, W15=0, `blk_last`=0.
  - Block 2: W0..W13=0, W15=0x000001C0, `blk_last`=1, `blk_first`=0.
  - Block 2's `blk_valid` is asserted the cycle after block 1's handshake.
- **64 bytes** (16 words, last k=4).
  - Block 2: W0=0x80000000, W15=0x00000200.
- **Backpressure:** hold `blk_ready`=0 for 5 cycles while in EMIT.
  - `blk_W` and the flags stay stable, `in_ready`=0, and `in_valid` words are not consumed.
  - The handshake completes on the cycle `blk_ready` goes to 1.
- **Reset mid-message:** drop `reset` after 7 words, then send "abc".
  - Output is the single "abc" block above with `blk_first`=1 and L=0x18.
  - No residue from the first 7 words.
